// File: rtl/tank_hit_ctrl_if.sv
// Tank hit controller bus: bullet/tank positions in, hit status out.
interface tank_hit_ctrl_if;
    logic [9:0] Tank_X;
    logic [9:0] Tank_Y;
    logic [9:0] Bullet_X;
    logic [9:0] Bullet_Y;
    logic       bullet_active;
    logic       bull_collide_flag;
    logic       bullet_kill;
    logic [3:0] health;
    logic       tank_dead;
    logic       invuln;

    // Driver of positions, consumer of hit status.
    modport master (
        output Tank_X, Tank_Y, Bullet_X, Bullet_Y, bullet_active,
        input  bull_collide_flag, bullet_kill, health, tank_dead, invuln
    );

    // The hit controller itself.
    modport slave (
        input  Tank_X, Tank_Y, Bullet_X, Bullet_Y, bullet_active,
        output bull_collide_flag, bullet_kill, health, tank_dead, invuln
    );
endinterface

// File: rtl/tank_hit_ctrl.sv
// Per-frame bullet/tank collision test with saturating health and a
// post-hit invulnerability window.
//
// state  | meaning
// -------+-------------------------------------------------------------
// ALIVE  | hittable; an overlap costs DAMAGE and pulses flag/kill
// INVULN | hits ignored; cnt_q counts down the remaining frames
// DEAD   | health is 0; absorbing until Reset
module tank_hit_ctrl #(
    parameter logic [3:0] HEALTH_INIT   = 4'd5,
    parameter logic [3:0] DAMAGE        = 4'd1,
    parameter logic [9:0] HIT_RADIUS    = 10'd18,
    parameter logic [9:0] INVULN_FRAMES = 10'd60
) (
    input  logic            frame_clk,
    input  logic            Reset,
    tank_hit_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {ALIVE = 2'd0, INVULN = 2'd1, DEAD = 2'd2} state_t;

    state_t      state_q, state_d;
    logic [3:0]  health_q, health_d;
    logic [9:0]  cnt_q, cnt_d;
    logic        flag_q, kill_q, pulse_d;
    logic        dead_q, dead_d;
    logic        invuln_q, invuln_d;

    logic signed [10:0] diff_x, diff_y;
    logic        [10:0] dx, dy;
    logic               overlap;
    logic        [3:0]  health_hit;

    // Signed 11-bit differences avoid unsigned wrap near the screen origin.
    always_comb begin
        diff_x  = $signed({1'b0, bus.Bullet_X}) - $signed({1'b0, bus.Tank_X});
        diff_y  = $signed({1'b0, bus.Bullet_Y}) - $signed({1'b0, bus.Tank_Y});
        dx      = diff_x[10] ? $unsigned(-diff_x) : $unsigned(diff_x);
        dy      = diff_y[10] ? $unsigned(-diff_y) : $unsigned(diff_y);
        overlap = bus.bullet_active
                  && (dx <= {1'b0, HIT_RADIUS})
                  && (dy <= {1'b0, HIT_RADIUS});
        health_hit = (health_q > DAMAGE) ? (health_q - DAMAGE) : 4'd0;
    end

    // State and registered outputs.
    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            state_q  <= ALIVE;
            health_q <= HEALTH_INIT;
            cnt_q    <= 10'd0;
            flag_q   <= 1'b0;
            kill_q   <= 1'b0;
            dead_q   <= 1'b0;
            invuln_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            health_q <= health_d;
            cnt_q    <= cnt_d;
            flag_q   <= pulse_d;
            kill_q   <= pulse_d;
            dead_q   <= dead_d;
            invuln_q <= invuln_d;
        end
    end

    // Next-state selection.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ALIVE:   if (overlap) state_d = (health_hit == 4'd0) ? DEAD : INVULN;
            INVULN:  if (cnt_q == 10'd0) state_d = ALIVE;
            default: state_d = state_q;
        endcase
    end

    // Next values of health, window counter and output flags.
    always_comb begin
        health_d = health_q;
        cnt_d    = cnt_q;
        pulse_d  = 1'b0;
        dead_d   = dead_q;
        invuln_d = invuln_q;
        case (state_q)
            ALIVE: begin
                if (overlap) begin
                    health_d = health_hit;
                    pulse_d  = 1'b1;
                    if (health_hit == 4'd0) begin
                        dead_d = 1'b1;
                    end else begin
                        invuln_d = 1'b1;
                        cnt_d    = INVULN_FRAMES - 10'd1;
                    end
                end
            end
            INVULN: begin
                // An overlap on the release edge is still ignored.
                if (cnt_q == 10'd0) invuln_d = 1'b0;
                else                cnt_d    = cnt_q - 10'd1;
            end
            default: ;
        endcase
    end

    assign bus.bull_collide_flag = flag_q;
    assign bus.bullet_kill       = kill_q;
    assign bus.health            = health_q;
    assign bus.tank_dead         = dead_q;
    assign bus.invuln            = invuln_q;

endmodule

// File: tb/tb_tank_hit_ctrl.sv
// Directed bench for tank_hit_ctrl; second instance exercises DAMAGE=7.
module tb_tank_hit_ctrl;

    logic frame_clk = 1'b0;
    logic Reset     = 1'b1;
    int   checks    = 0;
    int   failures  = 0;

    tank_hit_ctrl_if bus  ();
    tank_hit_ctrl_if bus7 ();

    tank_hit_ctrl dut (
        .frame_clk (frame_clk),
        .Reset     (Reset),
        .bus       (bus)
    );

    tank_hit_ctrl #(.DAMAGE(4'd7)) dut7 (
        .frame_clk (frame_clk),
        .Reset     (Reset),
        .bus       (bus7)
    );

    always #5 frame_clk = ~frame_clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running, required finished");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge frame_clk);
        #1;
    endtask

    task automatic set_in(input logic [9:0] tx, input logic [9:0] ty,
                          input logic [9:0] bx, input logic [9:0] by,
                          input logic act);
        bus.Tank_X = tx;  bus.Tank_Y = ty;
        bus.Bullet_X = bx; bus.Bullet_Y = by;
        bus.bullet_active = act;
        bus7.Tank_X = tx;  bus7.Tank_Y = ty;
        bus7.Bullet_X = bx; bus7.Bullet_Y = by;
        bus7.bullet_active = act;
    endtask

    task automatic do_reset();
        tick();
        Reset = 1'b1;
        #2;
        Reset = 1'b0;
    endtask

    task automatic test_reset();
        set_in(10'd320, 10'd240, 10'd330, 10'd250, 1'b1);
        Reset = 1'b1;
        tick();
        checks++;
        if (bus.health !== 4'd5 || bus.bull_collide_flag !== 1'b0 || bus.bullet_kill !== 1'b0
            || bus.tank_dead !== 1'b0 || bus.invuln !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: got h=%0d f=%b k=%b d=%b i=%b, required h=5 f=0 k=0 d=0 i=0",
                     bus.health, bus.bull_collide_flag, bus.bullet_kill, bus.tank_dead, bus.invuln);
        end
        Reset = 1'b0;
    endtask

    task automatic test_single_hit();
        int inv_frames;
        // overlap already present; first edge after release registers it
        tick();
        checks++;
        if (bus.bull_collide_flag !== 1'b1 || bus.bullet_kill !== 1'b1 || bus.health !== 4'd4
            || bus.invuln !== 1'b1) begin
            failures++;
            $display("FAIL single_hit: got f=%b k=%b h=%0d i=%b, required f=1 k=1 h=4 i=1",
                     bus.bull_collide_flag, bus.bullet_kill, bus.health, bus.invuln);
        end
        inv_frames = 1;
        set_in(10'd320, 10'd240, 10'd330, 10'd250, 1'b0);
        tick();
        checks++;
        if (bus.bull_collide_flag !== 1'b0 || bus.bullet_kill !== 1'b0) begin
            failures++;
            $display("FAIL pulse_width: got f=%b k=%b, required f=0 k=0",
                     bus.bull_collide_flag, bus.bullet_kill);
        end
        for (int i = 0; i < 80; i++) begin
            if (bus.invuln === 1'b1) inv_frames++;
            tick();
        end
        checks++;
        if (inv_frames !== 60) begin
            failures++;
            $display("FAIL invuln_length: got %0d frames, required 60", inv_frames);
        end
    endtask

    task automatic test_held();
        int hits[$];
        int exp_hits[4];
        exp_hits = '{1, 62, 123, 184};
        do_reset();
        set_in(10'd320, 10'd240, 10'd338, 10'd222, 1'b1);
        for (int i = 1; i <= 200; i++) begin
            tick();
            if (bus.bull_collide_flag === 1'b1) hits.push_back(i);
            if (bus.bullet_kill !== bus.bull_collide_flag) begin
                checks++;
                failures++;
                $display("FAIL kill_coincident: frame %0d got k=%b, required k=%b",
                         i, bus.bullet_kill, bus.bull_collide_flag);
            end
        end
        checks++;
        if (hits.size() !== 4) begin
            failures++;
            $display("FAIL held_pulse_count: got %0d, required 4", hits.size());
        end else begin
            for (int j = 0; j < 4; j++) begin
                checks++;
                if (hits[j] !== exp_hits[j]) begin
                    failures++;
                    $display("FAIL held_hit_frame[%0d]: got %0d, required %0d", j, hits[j], exp_hits[j]);
                end
            end
        end
        checks++;
        if (bus.health !== 4'd1) begin
            failures++;
            $display("FAIL held_health: got %0d, required 1", bus.health);
        end
    endtask

    task automatic test_boundary();
        int pulses;
        do_reset();
        set_in(10'd320, 10'd240, 10'd339, 10'd240, 1'b1);
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus.bull_collide_flag === 1'b1) pulses++;
        end
        checks++;
        if (pulses !== 0 || bus.health !== 4'd5) begin
            failures++;
            $display("FAIL radius_plus_one: got pulses=%0d h=%0d, required pulses=0 h=5", pulses, bus.health);
        end
        set_in(10'd1000, 10'd1000, 10'd0, 10'd0, 1'b1);
        tick();
        tick();
        checks++;
        if (bus.bull_collide_flag !== 1'b0 || bus.health !== 4'd5) begin
            failures++;
            $display("FAIL far_no_wrap: got f=%b h=%0d, required f=0 h=5", bus.bull_collide_flag, bus.health);
        end
        set_in(10'd2, 10'd2, 10'd5, 10'd5, 1'b1);
        tick();
        checks++;
        if (bus.bull_collide_flag !== 1'b1 || bus.health !== 4'd4) begin
            failures++;
            $display("FAIL near_origin_hit: got f=%b h=%0d, required f=1 h=4", bus.bull_collide_flag, bus.health);
        end
    endtask

    task automatic test_dead();
        do_reset();
        for (int n = 1; n <= 5; n++) begin
            set_in(10'd320, 10'd240, 10'd302, 10'd258, 1'b1);
            tick();
            checks++;
            if (bus.bull_collide_flag !== 1'b1 || bus.health !== 4'(5 - n)
                || bus.tank_dead !== (n == 5)) begin
                failures++;
                $display("FAIL spaced_hit[%0d]: got f=%b h=%0d d=%b, required f=1 h=%0d d=%b",
                         n, bus.bull_collide_flag, bus.health, bus.tank_dead, 5 - n, n == 5);
            end
            set_in(10'd320, 10'd240, 10'd302, 10'd258, 1'b0);
            for (int i = 0; i < 60; i++) tick();
        end
        set_in(10'd320, 10'd240, 10'd320, 10'd240, 1'b1);
        tick();
        tick();
        checks++;
        if (bus.bull_collide_flag !== 1'b0 || bus.health !== 4'd0 || bus.tank_dead !== 1'b1) begin
            failures++;
            $display("FAIL dead_absorbs: got f=%b h=%0d d=%b, required f=0 h=0 d=1",
                     bus.bull_collide_flag, bus.health, bus.tank_dead);
        end
    endtask

    task automatic test_inactive();
        int pulses;
        do_reset();
        set_in(10'd320, 10'd240, 10'd320, 10'd240, 1'b0);
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (bus.bull_collide_flag === 1'b1) pulses++;
        end
        checks++;
        if (pulses !== 0 || bus.health !== 4'd5) begin
            failures++;
            $display("FAIL inactive_no_hit: got pulses=%0d h=%0d, required pulses=0 h=5", pulses, bus.health);
        end
    endtask

    task automatic test_damage7();
        do_reset();
        set_in(10'd320, 10'd240, 10'd325, 10'd235, 1'b1);
        tick();
        checks++;
        if (bus7.bull_collide_flag !== 1'b1 || bus7.health !== 4'd0 || bus7.tank_dead !== 1'b1
            || bus7.invuln !== 1'b0) begin
            failures++;
            $display("FAIL damage7_saturate: got f=%b h=%0d d=%b i=%b, required f=1 h=0 d=1 i=0",
                     bus7.bull_collide_flag, bus7.health, bus7.tank_dead, bus7.invuln);
        end
    endtask

    task automatic test_reset_mid_invuln();
        do_reset();
        set_in(10'd320, 10'd240, 10'd330, 10'd250, 1'b1);
        tick();
        for (int i = 0; i < 20; i++) tick();
        checks++;
        if (bus.invuln !== 1'b1 || bus.health !== 4'd4) begin
            failures++;
            $display("FAIL pre_reset_invuln: got i=%b h=%0d, required i=1 h=4", bus.invuln, bus.health);
        end
        #1;
        Reset = 1'b1;
        #1;
        checks++;
        if (bus.invuln !== 1'b0 || bus.health !== 4'd5) begin
            failures++;
            $display("FAIL async_reset: got i=%b h=%0d, required i=0 h=5", bus.invuln, bus.health);
        end
        #1;
        Reset = 1'b0;
        tick();
        checks++;
        if (bus.bull_collide_flag !== 1'b1 || bus.health !== 4'd4) begin
            failures++;
            $display("FAIL hit_after_release: got f=%b h=%0d, required f=1 h=4",
                     bus.bull_collide_flag, bus.health);
        end
    endtask

    initial begin
        test_reset();
        test_single_hit();
        test_held();
        test_boundary();
        test_dead();
        test_inactive();
        test_damage7();
        test_reset_mid_invuln();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tank_hit_ctrl.md
Name: tank_hit_ctrl

Overview:
- Upstream of the on-screen hit-text stage.
- Each frame it tests the active bullet against the tank bounding box and applies damage to a saturating health counter.
- On a valid hit it emits a one-frame bull_collide_flag pulse and a bullet-kill request.
- After a hit it enforces an invulnerability window so that one bullet lingering over the tank cannot deal repeated damage.

Parameters:
- HEALTH_INIT, 4'd5, health value loaded at reset (1..15).
- DAMAGE, 4'd1, health removed per valid hit (1..15).
- HIT_RADIUS, 10'd18, tank half-size plus bullet half-size; the hit window on each axis.
- INVULN_FRAMES, 10'd60, number of frames hits are ignored after a valid hit (1..1023).

Ports:
- frame_clk  in  1  frame-rate clock; all state updates on its rising edge.
- Reset  in  1  asynchronous, active-high reset.
- Tank_X  in  10  tank centre X, in pixels.
- Tank_Y  in  10  tank centre Y, in pixels.
- Bullet_X  in  10  bullet centre X, in pixels.
- Bullet_Y  in  10  bullet centre Y, in pixels.
- bullet_active  in  1  bullet is in flight and may hit.
- bull_collide_flag  out  1  one-frame pulse per valid hit.
- bullet_kill  out  1  one-frame pulse, coincident with bull_collide_flag; the bullet block despawns on it.
- health  out  4  current health.
- tank_dead  out  1  level; high once health reaches 0.
- invuln  out  1  level; high while hits are ignored.

Behaviour:
- All outputs are registered.
- Reset values: health=HEALTH_INIT, bull_collide_flag=0, bullet_kill=0, tank_dead=0, invuln=0, counter=0, state=ALIVE. Reset acts asynchronously on assertion.
- Overlap (combinational):
  - dx = |Bullet_X - Tank_X| and dy = |Bullet_Y - Tank_Y|, each computed as an 11-bit signed difference followed by absolute value, so there is no unsigned wrap.
  - overlap = bullet_active && dx <= HIT_RADIUS && dy <= HIT_RADIUS. Boundary is inclusive.
- State machine:
  - ALIVE:
    - If overlap: health <= sat(health - DAMAGE), with a floor of 0. Pulse bull_collide_flag and bullet_kill for the next frame only.
    - If the new health == 0, go to DEAD and set tank_dead=1.
    - Otherwise go to INVULN, load counter=INVULN_FRAMES-1, set invuln=1.
  - INVULN:
    - overlap is ignored: no pulse, no damage, no bullet_kill.
    - counter decrements each frame. When counter==0 at an edge, go to ALIVE with invuln=0.
    - An overlap on that same edge is still ignored; the tank becomes hittable on the next edge.
  - DEAD:
    - Absorbing state; health stays 0 and all hits are ignored.
    - Only Reset leaves DEAD.
- Latency: overlap sampled at edge N gives bull_collide_flag=1 during frame N+1 and 0 at N+2. health and tank_dead update at the same edge as the pulse.
- The killing hit still pulses bull_collide_flag, so downstream sees health==0 together with the flag and can pick "destroyed" text.
- A continuous overlap in ALIVE that has not resolved yields exactly one pulse per entry into ALIVE.
- bullet_active low suppresses overlap regardless of position.
- Reset asserted mid-INVULN or in DEAD returns all state to reset values immediately. The first hit can register on the first edge after Reset deasserts.
- Pulse width is exactly one frame_clk cycle. The pulse is never stretched by the same bullet.

Test Plan:
- Reset, Tank=(320,240), Bullet=(330,250), bullet_active=1 for 1 frame -> flag and kill pulse one frame; health 5->4; invuln=1 for 60 frames.
- Bullet held at Tank+(18,-18) for 200 frames -> hits at frames 1, 62, 123, 184; health 5->1; exactly one pulse per hit.
- Bullet at Tank+(19,0), active -> no pulse, health stays 5. Bullet at (5,5) with Tank at (2,2) -> dx=3, hit, no wrap artefact.
- Five spaced hits -> fifth pulse coincides with health=0 and tank_dead=1; a sixth overlap gives no pulse, health stays 0.
- Overlap with bullet_active=0 -> no pulse. DAMAGE=7 with health=5 -> health saturates to 0 and tank_dead=1.
- Reset asserted at frame 20 of INVULN -> invuln=0 and health=5 immediately; an overlap on the first edge after release -> pulse and health=4.
